// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: turns SPI slave frames into address-register updates and RAM
// accesses, and shares the single RAM port with a local host.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [MEM_WIDTH-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [MEM_WIDTH-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_wdata,
    input  logic [MEM_WIDTH-1:0] ram_rdata,
    output logic                 spi_ovf
);

    if (MEM_WIDTH != ADDR_SIZE) begin : g_width_check
        $fatal(1, "spi_ram_arbiter: MEM_WIDTH must equal ADDR_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] rd_addr_r;
    logic                 buf_v_r;
    logic                 buf_we_r;
    logic [ADDR_SIZE-1:0] buf_addr_r;
    logic [MEM_WIDTH-1:0] buf_data_r;
    logic                 last_host_r;
    logic                 win_host_r;
    logic                 acc_rd_r;

    logic [1:0]           cmd_s;
    logic [ADDR_SIZE-1:0] payload_s;
    logic                 ram_frame_s;
    logic                 spi_clr_s;
    logic                 grant_s;
    logic                 pick_host_s;

    assign cmd_s       = rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign payload_s   = rx_data[ADDR_SIZE-1:0];
    assign ram_frame_s = rx_valid & cmd_s[0];
    // The buffer frees at the end of the SPI access cycle, so a frame arriving then still fits.
    assign spi_clr_s   = (state_r == ACC) & ~win_host_r;

    // Arbitration: choose the winner among the buffered SPI access and the host while IDLE.
    always_comb begin
        grant_s     = 1'b0;
        pick_host_s = 1'b0;
        if (state_r == IDLE) begin
            grant_s = buf_v_r | host_req;
            if (buf_v_r && host_req) begin
                pick_host_s = RR_EN ? ~last_host_r : 1'b0;
            end else begin
                pick_host_s = host_req;
            end
        end else begin
            grant_s     = 1'b0;
            pick_host_s = 1'b0;
        end
    end

    // Next-state logic: IDLE -> ACC -> (read ? RESP : IDLE), RESP -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (acc_rd_r) begin
                    state_s = RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and registered RAM port; ram_en is a one-cycle pulse launched from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= {ADDR_SIZE{1'b0}};
            ram_wdata   <= {MEM_WIDTH{1'b0}};
            host_gnt    <= 1'b0;
            last_host_r <= 1'b1;
            win_host_r  <= 1'b0;
            acc_rd_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            ram_en   <= grant_s;
            host_gnt <= grant_s & pick_host_s;
            if (grant_s) begin
                last_host_r <= pick_host_s;
                win_host_r  <= pick_host_s;
                if (pick_host_s) begin
                    ram_we    <= host_we;
                    ram_addr  <= host_addr;
                    ram_wdata <= host_wdata;
                    acc_rd_r  <= ~host_we;
                end else begin
                    ram_we    <= buf_we_r;
                    ram_addr  <= buf_addr_r;
                    ram_wdata <= buf_data_r;
                    acc_rd_r  <= ~buf_we_r;
                end
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

    // SPI frame decode: address registers, the one-entry access buffer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r  <= {ADDR_SIZE{1'b0}};
            rd_addr_r  <= {ADDR_SIZE{1'b0}};
            buf_v_r    <= 1'b0;
            buf_we_r   <= 1'b0;
            buf_addr_r <= {ADDR_SIZE{1'b0}};
            buf_data_r <= {MEM_WIDTH{1'b0}};
            spi_ovf    <= 1'b0;
        end else begin
            if (rx_valid && !cmd_s[0]) begin
                if (cmd_s[1]) begin
                    rd_addr_r <= payload_s;
                end else begin
                    wr_addr_r <= payload_s;
                end
            end
            // Address registers are read before this cycle's update takes effect.
            if (ram_frame_s && (!buf_v_r || spi_clr_s)) begin
                buf_v_r    <= 1'b1;
                buf_we_r   <= ~cmd_s[1];
                buf_addr_r <= cmd_s[1] ? rd_addr_r : wr_addr_r;
                buf_data_r <= payload_s;
            end else if (spi_clr_s) begin
                buf_v_r <= 1'b0;
            end
            if (ram_frame_s && buf_v_r && !spi_clr_s) begin
                spi_ovf <= 1'b1;
            end
        end
    end

    // Read-data return: capture ram_rdata in RESP and pulse the owner's valid next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= {MEM_WIDTH{1'b0}};
            tx_valid    <= 1'b0;
            host_rdata  <= {MEM_WIDTH{1'b0}};
            host_rvalid <= 1'b0;
        end else begin
            tx_valid    <= (state_r == RESP) & ~win_host_r;
            host_rvalid <= (state_r == RESP) & win_host_r;
            if (state_r == RESP) begin
                if (win_host_r) begin
                    host_rdata <= ram_rdata;
                end else begin
                    tx_data <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: drives a round-robin and a fixed-priority arbiter with directed and
// random traffic and compares every cycle against a transaction-level reference model.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] rx_data = 10'd0;
    logic       rx_valid = 1'b0;

    logic [7:0] tx_data [2];
    logic       tx_valid [2];
    logic       host_req [2];
    logic       host_we [2];
    logic [7:0] host_addr [2];
    logic [7:0] host_wdata [2];
    logic       host_gnt [2];
    logic [7:0] host_rdata [2];
    logic       host_rvalid [2];
    logic       ram_en [2];
    logic       ram_we [2];
    logic [7:0] ram_addr [2];
    logic [7:0] ram_wdata [2];
    logic [7:0] ram_rdata [2];
    logic       spi_ovf [2];

    logic [7:0] ram_mem [2][256] = '{default: 8'h00};

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .host_req(host_req[0]), .host_we(host_we[0]), .host_addr(host_addr[0]),
        .host_wdata(host_wdata[0]), .host_gnt(host_gnt[0]), .host_rdata(host_rdata[0]),
        .host_rvalid(host_rvalid[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .spi_ovf(spi_ovf[0])
    );

    spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .host_req(host_req[1]), .host_we(host_we[1]), .host_addr(host_addr[1]),
        .host_wdata(host_wdata[1]), .host_gnt(host_gnt[1]), .host_rdata(host_rdata[1]),
        .host_rvalid(host_rvalid[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .spi_ovf(spi_ovf[1])
    );

    // Synchronous single-port RAM behind each arbiter.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_en[i]) begin
                if (ram_we[i]) ram_mem[i][ram_addr[i]] <= ram_wdata[i];
                else           ram_rdata[i] <= ram_mem[i][ram_addr[i]];
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic string tg(input int i, input string name);
        return $sformatf("u%0d.%s@%0d", i, name, cyc);
    endfunction

    // Reference model: what each cycle must show, scheduled from the spec's latencies.
    typedef struct packed {
        bit       en;
        bit       we;
        bit       gnt;
        bit       txv;
        bit       hrv;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [7:0] rdata;
    } ev_t;

    ev_t      sched [2][4];
    bit [7:0] m_wr [2], m_rd [2], m_baddr [2], m_bdata [2], m_txd [2], m_hrd [2];
    bit       m_bv [2], m_bwe [2], m_ovf [2], m_last_host [2];
    int       m_free_at [2], m_clr_at [2];
    bit [7:0] m_mem [2][256];

    logic       want_req [2];
    logic       want_we [2];
    logic [7:0] want_addr [2];
    logic [7:0] want_wdata [2];

    task automatic model_reset(input int i);
        m_wr[i] = 8'h00; m_rd[i] = 8'h00; m_baddr[i] = 8'h00; m_bdata[i] = 8'h00;
        m_txd[i] = 8'h00; m_hrd[i] = 8'h00;
        m_bv[i] = 1'b0; m_bwe[i] = 1'b0; m_ovf[i] = 1'b0; m_last_host[i] = 1'b1;
        m_free_at[i] = 0; m_clr_at[i] = -1;
        for (int j = 0; j < 4; j++) sched[i][j] = '0;
    endtask

    task automatic model_step(input int i);
        bit spi, hst, ph, we;
        bit [7:0] ad, wd, pay;
        bit [1:0] cmd;
        for (int j = 0; j < 3; j++) sched[i][j] = sched[i][j+1];
        sched[i][3] = '0;
        if (m_free_at[i] <= cyc) begin
            spi = m_bv[i];
            hst = host_req[i];
            if (spi || hst) begin
                if (spi && hst) ph = (i == 0) ? !m_last_host[i] : 1'b0;
                else            ph = hst;
                we = ph ? host_we[i]    : m_bwe[i];
                ad = ph ? host_addr[i]  : m_baddr[i];
                wd = ph ? host_wdata[i] : m_bdata[i];
                sched[i][0].en    = 1'b1;
                sched[i][0].we    = we;
                sched[i][0].addr  = ad;
                sched[i][0].wdata = wd;
                sched[i][0].gnt   = ph;
                if (we) begin
                    m_mem[i][ad] = wd;
                end else begin
                    sched[i][2].txv   = !ph;
                    sched[i][2].hrv   = ph;
                    sched[i][2].rdata = m_mem[i][ad];
                end
                m_free_at[i]   = cyc + (we ? 2 : 3);
                m_last_host[i] = ph;
                if (!ph) m_clr_at[i] = cyc + 1;
            end
        end
        if (m_clr_at[i] == cyc) m_bv[i] = 1'b0;
        if (rx_valid) begin
            cmd = rx_data[9:8];
            pay = rx_data[7:0];
            case (cmd)
                2'b00: m_wr[i] = pay;
                2'b10: m_rd[i] = pay;
                default: begin
                    if (m_bv[i]) begin
                        m_ovf[i] = 1'b1;
                    end else begin
                        m_bv[i]    = 1'b1;
                        m_bwe[i]   = (cmd == 2'b01);
                        m_baddr[i] = (cmd == 2'b01) ? m_wr[i] : m_rd[i];
                        m_bdata[i] = pay;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs(input int i);
        ev_t e;
        e = sched[i][0];
        if (e.txv) m_txd[i] = e.rdata;
        if (e.hrv) m_hrd[i] = e.rdata;
        check_eq(tg(i, "ram_en"), ram_en[i], e.en);
        check_eq(tg(i, "ram_we"), ram_we[i], e.en & e.we);
        if (e.en) check_eq(tg(i, "ram_addr"), ram_addr[i], e.addr);
        if (e.en && e.we) check_eq(tg(i, "ram_wdata"), ram_wdata[i], e.wdata);
        check_eq(tg(i, "host_gnt"), host_gnt[i], e.gnt);
        check_eq(tg(i, "tx_valid"), tx_valid[i], e.txv);
        check_eq(tg(i, "tx_data"), tx_data[i], m_txd[i]);
        check_eq(tg(i, "host_rvalid"), host_rvalid[i], e.hrv);
        check_eq(tg(i, "host_rdata"), host_rdata[i], m_hrd[i]);
        check_eq(tg(i, "spi_ovf"), spi_ovf[i], m_ovf[i]);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq({tag, "_ram_en"}, ram_en[i], 1'b0);
            check_eq({tag, "_ram_we"}, ram_we[i], 1'b0);
            check_eq({tag, "_ram_addr"}, ram_addr[i], 8'h00);
            check_eq({tag, "_ram_wdata"}, ram_wdata[i], 8'h00);
            check_eq({tag, "_host_gnt"}, host_gnt[i], 1'b0);
            check_eq({tag, "_tx_valid"}, tx_valid[i], 1'b0);
            check_eq({tag, "_tx_data"}, tx_data[i], 8'h00);
            check_eq({tag, "_host_rvalid"}, host_rvalid[i], 1'b0);
            check_eq({tag, "_host_rdata"}, host_rdata[i], 8'h00);
            check_eq({tag, "_spi_ovf"}, spi_ovf[i], 1'b0);
        end
    endtask

    // One clock cycle: host handshake, compare, advance the model, then the clock.
    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            if (host_req[i] && host_gnt[i]) host_req[i] = 1'b0;
            if (want_req[i] && !host_req[i]) begin
                host_req[i]   = 1'b1;
                host_we[i]    = want_we[i];
                host_addr[i]  = want_addr[i];
                host_wdata[i] = want_wdata[i];
            end
            want_req[i] = 1'b0;
            check_outputs(i);
            model_step(i);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] pay);
        rx_data  = {cmd, pay};
        rx_valid = 1'b1;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic host_want(input logic we, input logic [7:0] a, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            want_req[i] = 1'b1; want_we[i] = we; want_addr[i] = a; want_wdata[i] = d;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            host_req[i] = 1'b0; host_we[i] = 1'b0; host_addr[i] = 8'h00; host_wdata[i] = 8'h00;
            want_req[i] = 1'b0; want_we[i] = 1'b0; want_addr[i] = 8'h00; want_wdata[i] = 8'h00;
            model_reset(i);
        end
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Reset in the middle of an SPI read: everything drops at once, no late tx_valid.
        send(2'b10, 8'h55);
        send(2'b11, 8'h00);
        idle(2);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid_read");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) model_reset(i);
        idle(6);

        // SPI write then read back at 0x3C.
        send(2'b00, 8'h3C);
        send(2'b01, 8'hA5);
        send(2'b10, 8'h3C);
        send(2'b11, 8'h00);
        idle(6);
        check_eq("t2_tx_data", tx_data[0], 8'hA5);
        check_eq("t2_ram_3c", ram_mem[0][8'h3C], 8'hA5);

        // Host write so last grant is HOST, then host read vs buffered SPI write.
        host_want(1'b1, 8'h20, 8'h11);
        idle(4);
        send(2'b00, 8'h3C);
        send(2'b01, 8'h5A);
        host_want(1'b0, 8'h3C, 8'h00);
        idle(8);
        check_eq("t3_host_rdata", host_rdata[0], 8'h5A);
        check_eq("t3_host_rdata_fp", host_rdata[1], 8'h5A);

        // Write frame followed by a wr_addr change before the grant.
        send(2'b00, 8'h40);
        send(2'b01, 8'h77);
        send(2'b00, 8'h10);
        idle(6);
        check_eq("t6_ram_40", ram_mem[0][8'h40], 8'h77);
        check_eq("t6_ram_10", ram_mem[0][8'h10], 8'h00);
        check_eq("t6_no_ovf", spi_ovf[0], 1'b0);

        // Two write frames while the host read owns the RAM: second is dropped.
        host_want(1'b0, 8'h20, 8'h00);
        idle(1);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        idle(8);
        check_eq("t5_ovf", spi_ovf[0], 1'b1);
        idle(4);
        check_eq("t5_ovf_sticky", spi_ovf[0], 1'b1);

        // Sustained contention: round-robin alternates, fixed priority favours SPI.
        for (int k = 0; k < 40; k++) begin
            host_want(1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            if (k % 2 == 0) begin
                send(2'b01, 8'($urandom));
            end else begin
                cycle();
            end
        end
        idle(6);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                want_req[i]   = ($urandom_range(0, 2) == 0);
                want_we[i]    = 1'($urandom_range(0, 1));
                want_addr[i]  = 8'($urandom_range(0, 15));
                want_wdata[i] = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                rx_data[9:8] = 2'($urandom_range(0, 3));
                rx_data[7:0] = rx_data[8] ? 8'($urandom) : 8'($urandom_range(0, 15));
                rx_valid = 1'b1;
            end
            cycle();
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
